button_debounce_io: RTL and testbench

// Bus-mapped multi-channel push-button input peripheral. Each channel has a
// 2-flop synchroniser, a per-channel debounce counter and press/release edge

---
 rtl/button_debounce_io.sv | 76 +++++++
 tb/tb_button_debounce_io.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/button_debounce_io.sv
// button_debounce_io: bus-mapped push-button peripheral with per-channel synchroniser,
// debounce counter, sticky W1C press/release flags and a registered interrupt.
`ifndef IO_CTRL_READ
`define IO_CTRL_READ 1'b0
`endif
`ifndef IO_CTRL_WRITE
`define IO_CTRL_WRITE 1'b1
`endif
module button_debounce_io #(
    parameter int CPU_WIDTH = 16,
    parameter int BUTTON_NUM = 4,
    parameter int DB_CYCLES = 50000,
    parameter logic [CPU_WIDTH-1:0] BASE_ADDR = 16'hFF10,
    parameter logic INV_RST = 1'b1
) (
    input logic clk,
    input logic rst_n,
    input logic EN,
    input logic [CPU_WIDTH-1:0] addr,
    inout wire [CPU_WIDTH-1:0] data,
    input logic ctrl,
    input logic [BUTTON_NUM-1:0] button,
    output logic irq
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int N = BUTTON_NUM;
    logic [N-1:0] s1, s2, stable, ev, irqen, acc, new_ev, ev_nx, irqen_nx, level;
    logic [CW-1:0] cnt [N];
    logic [1:0] cfg, cfg_nx, idx;
    logic hit, we;
    logic [CPU_WIDTH-1:0] rdata_q, rsel, unused_data;
    assign unused_data = data;
    assign hit = addr[CPU_WIDTH-1:2] == BASE_ADDR[CPU_WIDTH-1:2];
    assign idx = addr[1:0];
    assign we = EN && ctrl == `IO_CTRL_WRITE && hit;
    assign level = stable ^ {N{cfg[0]}};
    always_comb begin
        for (int i = 0; i < N; i++) begin
            acc[i] = s2[i] != stable[i] && cnt[i] == CW'(DB_CYCLES - 1);
            // a newly accepted level is a press when it matches the active polarity
            new_ev[i] = acc[i] && (s2[i] == ~cfg[0] || cfg[1]);
        end
        ev_nx = ((we && idx == 2'd1) ? ev & ~data[N-1:0] : ev) | new_ev;
        irqen_nx = (we && idx == 2'd2) ? data[N-1:0] : irqen;
        cfg_nx = (we && idx == 2'd3) ? data[1:0] : cfg;
        rsel = '0;
        rsel[N-1:0] = idx == 2'd0 ? level : idx == 2'd1 ? ev : idx == 2'd2 ? irqen : '0;
        if (idx == 2'd3) rsel[1:0] = cfg;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= {N{INV_RST}};
            s2 <= {N{INV_RST}};
            stable <= {N{INV_RST}};
            for (int i = 0; i < N; i++) cnt[i] <= '0;
            ev <= '0;
            irqen <= '0;
            cfg <= {1'b0, INV_RST};
            rdata_q <= '0;
            irq <= 1'b0;
        end else begin
            s1 <= button;
            s2 <= s1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) stable[i] <= s2[i];
                cnt[i] <= (s2[i] == stable[i] || acc[i]) ? '0 : cnt[i] + 1'b1;
            end
            ev <= ev_nx;
            irqen <= irqen_nx;
            cfg <= cfg_nx;
            rdata_q <= rsel;
            irq <= |(ev_nx & irqen_nx);
        end
    end
    assign data = (EN && ctrl == `IO_CTRL_READ && hit) ? rdata_q : 'z;
endmodule

// File: tb/tb_button_debounce_io.sv
// tb_button_debounce_io: directed bench for button_debounce_io with DB_CYCLES=4.
`ifndef IO_CTRL_READ
`define IO_CTRL_READ 1'b0
`endif
`ifndef IO_CTRL_WRITE
`define IO_CTRL_WRITE 1'b1
`endif
module tb_button_debounce_io;
    logic clk = 1'b0, rst_n = 1'b0, EN = 1'b0, ctrl = `IO_CTRL_READ, drv = 1'b0;
    logic [15:0] addr = 16'hFF10, wdata = 16'h0000;
    logic [3:0] button = 4'hF;
    logic irq;
    wire [15:0] data;
    int checks = 0, fails = 0;
    typedef struct {
        logic [15:0] addr;
        logic en;
        logic drive;
        logic [15:0] exp;
    } rvec_t;
    rvec_t tbl [7];
    always #5 clk = ~clk;
    assign data = drv ? wdata : 'z;
    button_debounce_io #(.CPU_WIDTH(16), .BUTTON_NUM(4), .DB_CYCLES(4),
                         .BASE_ADDR(16'hFF10), .INV_RST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .EN(EN), .addr(addr), .data(data),
        .ctrl(ctrl), .button(button), .irq(irq));
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic rd(input logic [15:0] a, input logic en, output logic [15:0] v, output logic undriven);
        EN = en;
        ctrl = `IO_CTRL_READ;
        addr = a;
        drv = 1'b0;
        @(negedge clk);
        v = data;
        undriven = 1'b1;
        for (int b = 0; b < 16; b++) if (data[b] === 1'b1) undriven = 1'b0;
        EN = 1'b0;
    endtask
    task automatic rdchk(input string name, input logic [1:0] idx, input logic [15:0] exp);
        logic [15:0] v;
        logic u;
        rd(16'hFF10 | {14'b0, idx}, 1'b1, v, u);
        chk(name, v, exp);
    endtask
    task automatic wr(input logic [1:0] idx, input logic [15:0] val);
        EN = 1'b1;
        ctrl = `IO_CTRL_WRITE;
        addr = 16'hFF10 | {14'b0, idx};
        wdata = val;
        drv = 1'b1;
        @(negedge clk);
        EN = 1'b0;
        drv = 1'b0;
        ctrl = `IO_CTRL_READ;
    endtask
    task automatic run_table(input string tag);
        logic [15:0] v;
        logic u;
        for (int i = 0; i < 7; i++) begin
            rd(tbl[i].addr, tbl[i].en, v, u);
            if (tbl[i].drive) chk($sformatf("%s_rd%0d", tag, i), v, tbl[i].exp);
            else chk($sformatf("%s_undriven%0d", tag, i), {15'b0, u}, 16'h0001);
        end
    endtask
    initial begin
        tbl[0] = '{16'hFF10, 1'b1, 1'b1, 16'h0000};
        tbl[1] = '{16'hFF11, 1'b1, 1'b1, 16'h0000};
        tbl[2] = '{16'hFF12, 1'b1, 1'b1, 16'h0000};
        tbl[3] = '{16'hFF13, 1'b1, 1'b1, 16'h0001};
        tbl[4] = '{16'hFF13, 1'b0, 1'b0, 16'h0000};
        tbl[5] = '{16'hFF17, 1'b1, 1'b0, 16'h0000};
        tbl[6] = '{16'hFF03, 1'b1, 1'b0, 16'h0000};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_irq", {15'b0, irq}, 16'h0000);
        run_table("reset");
        // press ch0: level accepted 6 clk after the pin, visible on the bus one read clock later
        button = 4'hE;
        EN = 1'b1;
        addr = 16'hFF10;
        repeat (6) @(negedge clk);
        chk("press_level_at6", data, 16'h0000);
        @(negedge clk);
        chk("press_level_at7", data, 16'h0001);
        EN = 1'b0;
        rdchk("press_event", 2'd1, 16'h0001);
        chk("press_irq_disabled", {15'b0, irq}, 16'h0000);
        button = 4'hC;
        repeat (3) @(negedge clk);
        button = 4'hE;
        repeat (8) @(negedge clk);
        rdchk("glitch_level", 2'd0, 16'h0001);
        rdchk("glitch_event", 2'd1, 16'h0001);
        wr(2'd2, 16'h0001);
        chk("irq_set", {15'b0, irq}, 16'h0001);
        wr(2'd1, 16'h0001);
        chk("irq_clear", {15'b0, irq}, 16'h0000);
        rdchk("w1c_event", 2'd1, 16'h0000);
        // W1C of ch2 lands on the same edge as its press is accepted
        button = 4'hA;
        repeat (5) @(negedge clk);
        wr(2'd1, 16'h0004);
        rdchk("set_wins_event", 2'd1, 16'h0004);
        rdchk("set_wins_level", 2'd0, 16'h0005);
        chk("set_wins_irq", {15'b0, irq}, 16'h0000);
        wr(2'd1, 16'h0004);
        rdchk("ch2_cleared", 2'd1, 16'h0000);
        wr(2'd3, 16'h0003);
        button = 4'hB;
        repeat (8) @(negedge clk);
        rdchk("release_event", 2'd1, 16'h0001);
        chk("release_irq", {15'b0, irq}, 16'h0001);
        rdchk("release_level", 2'd0, 16'h0004);
        wr(2'd3, 16'h0002);
        rdchk("inv_level", 2'd0, 16'h000B);
        rdchk("inv_no_event", 2'd1, 16'h0001);
        rdchk("cfg_read", 2'd3, 16'h0002);
        wr(2'd0, 16'hFFFF);
        rdchk("level_ro", 2'd0, 16'h000B);
        wr(2'd2, 16'hFFFF);
        rdchk("irqen_upper_zero", 2'd2, 16'h000F);
        button = 4'hF;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midcount_irq", {15'b0, irq}, 16'h0000);
        run_table("midrst");
        repeat (8) @(negedge clk);
        rdchk("midrst_level_later", 2'd0, 16'h0000);
        rdchk("midrst_event_later", 2'd1, 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
